// File: rtl/motion_detect_stream.sv
// motion_detect_stream: grayscale background/frame difference, thresholded highlight, raster tracking.
// Define MOTION_DETECT_COUNT_EN to enable the per-frame motion-pixel count (motion_count is 0 otherwise).
module motion_detect_stream #(
    parameter int WIDTH = 720,
    parameter int HEIGHT = 540,
    parameter int PIX_W = 8,
    parameter logic [3*PIX_W-1:0] HIGHLIGHT_RGB = {{PIX_W{1'b1}}, {(2*PIX_W){1'b0}}}
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [3*PIX_W-1:0]                  bg_dout,
    input  logic                                bg_empty,
    output logic                                bg_rd_en,
    input  logic [3*PIX_W-1:0]                  fr_dout,
    input  logic                                fr_empty,
    output logic                                fr_rd_en,
    input  logic [PIX_W-1:0]                    threshold,
    output logic [3*PIX_W-1:0]                  out_din,
    input  logic                                out_full,
    output logic                                out_wr_en,
    output logic                                frame_done,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   motion_count
);
    localparam int CW = $clog2(WIDTH*HEIGHT+1);
    localparam int XW = $clog2(WIDTH+1);
    localparam int YW = $clog2(HEIGHT+1);
    typedef logic [PIX_W-1:0] chan_t;
    typedef logic [PIX_W+1:0] sum_t;
    typedef logic [3*PIX_W-1:0] pix_t;

    function automatic sum_t sum3(input pix_t p);
        return sum_t'(p[3*PIX_W-1:2*PIX_W]) + sum_t'(p[2*PIX_W-1:PIX_W]) + sum_t'(p[PIX_W-1:0]);
    endfunction

    logic advance, pop, s1_valid, s2_valid, s3_valid, last, x_end;
    sum_t s1_bg, s1_fr;
    pix_t s1_pix, s2_pix;
    chan_t s1_thr, s2_thr, s2_diff, gray_bg, gray_fr, thr_q, pix_thr;
    logic [CW-1:0] in_idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
`ifdef MOTION_DETECT_COUNT_EN
    logic s3_motion;
    logic [CW-1:0] acc;
`endif

    assign advance = ~s3_valid | ~out_full;
    assign pop = ~bg_empty & ~fr_empty & advance & ~reset;
    assign bg_rd_en = pop;
    assign fr_rd_en = pop;
    assign out_wr_en = s3_valid & ~out_full;
    assign x_end = x == XW'(WIDTH-1);
    assign last = x_end && y == YW'(HEIGHT-1);
    // The first pixel of a frame uses the threshold being captured on its own pop
    assign pix_thr = in_idx == '0 ? threshold : thr_q;
    assign gray_bg = chan_t'(s1_bg / sum_t'(3));
    assign gray_fr = chan_t'(s1_fr / sum_t'(3));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_idx     <= '0;
            thr_q      <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            s1_bg      <= '0;
            s1_fr      <= '0;
            s1_pix     <= '0;
            s1_thr     <= '0;
            s2_diff    <= '0;
            s2_pix     <= '0;
            s2_thr     <= '0;
            out_din    <= '0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
`ifdef MOTION_DETECT_COUNT_EN
            s3_motion    <= 1'b0;
            acc          <= '0;
            motion_count <= '0;
`endif
        end else begin
            if (pop) begin
                in_idx <= in_idx == CW'(WIDTH*HEIGHT-1) ? '0 : in_idx + CW'(1);
                if (in_idx == '0) thr_q <= threshold;
            end
            if (advance) begin
                s1_valid <= pop;
                s1_bg    <= sum3(bg_dout);
                s1_fr    <= sum3(fr_dout);
                s1_pix   <= fr_dout;
                s1_thr   <= pix_thr;
                s2_valid <= s1_valid;
                s2_diff  <= gray_fr > gray_bg ? gray_fr - gray_bg : gray_bg - gray_fr;
                s2_pix   <= s1_pix;
                s2_thr   <= s1_thr;
                s3_valid <= s2_valid;
                out_din  <= s2_diff > s2_thr ? HIGHLIGHT_RGB : s2_pix;
`ifdef MOTION_DETECT_COUNT_EN
                s3_motion <= s2_diff > s2_thr;
`endif
            end
            frame_done <= out_wr_en & last;
            if (out_wr_en) begin
                x <= x_end ? '0 : x + XW'(1);
                y <= x_end ? (last ? '0 : y + YW'(1)) : y;
`ifdef MOTION_DETECT_COUNT_EN
                acc <= last ? '0 : acc + CW'(s3_motion);
                if (last) motion_count <= acc + CW'(s3_motion);
`endif
            end
        end
    end

`ifndef MOTION_DETECT_COUNT_EN
    assign motion_count = '0;
`endif
endmodule

// File: tb/tb_motion_detect_stream.sv
// tb_motion_detect_stream: directed frames on a 4x2 raster checked against a pixel-level reference model.
module tb_motion_detect_stream;
    localparam int N = 8;

    logic clk = 1'b0, reset = 1'b1;
    logic [23:0] bg_dout = '0, fr_dout = '0, out_din;
    logic bg_empty = 1'b1, fr_empty = 1'b1, bg_rd_en, fr_rd_en;
    logic [7:0] threshold = '0;
    logic out_full = 1'b0, out_wr_en, frame_done;
    logic [3:0] motion_count;

    motion_detect_stream #(.WIDTH(4), .HEIGHT(2), .PIX_W(8)) dut (
        .clock(clk), .reset(reset),
        .bg_dout(bg_dout), .bg_empty(bg_empty), .bg_rd_en(bg_rd_en),
        .fr_dout(fr_dout), .fr_empty(fr_empty), .fr_rd_en(fr_rd_en),
        .threshold(threshold), .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
        .frame_done(frame_done), .motion_count(motion_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] pix; logic mot; int cyc; } exp_t;
    exp_t exq[$];
    logic [23:0] bgq[$], frq[$];
    int total = 0, bad = 0;
    int cyc = 0, in_cnt = 0, wcnt = 0, macc = 0, npop = 0, nwr = 0, done_cnt = 0, first_lat = -1;
    logic [7:0] fthr = '0;
    logic [3:0] mc_exp = '0;
    logic pend_done = 1'b0, chk_lat = 1'b0;
    logic [23:0] last_out = '0, first_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: grayscale = floor((R+G+B)/3), motion when |gray difference| strictly exceeds threshold
    function automatic exp_t model(input logic [23:0] b, input logic [23:0] f, input logic [7:0] t, input int c);
        exp_t e;
        int gb, gf, d;
        gb = (int'(b[23:16]) + int'(b[15:8]) + int'(b[7:0])) / 3;
        gf = (int'(f[23:16]) + int'(f[15:8]) + int'(f[7:0])) / 3;
        d = gf > gb ? gf - gb : gb - gf;
        e.mot = d > int'(t);
        e.pix = e.mot ? 24'hFF0000 : f;
        e.cyc = c;
        return e;
    endfunction

    always begin
        logic popped;
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("frame_done", frame_done, pend_done);
        chk("motion_count", motion_count, mc_exp);
        if (bg_rd_en !== fr_rd_en) chk("rd_en_pair", bg_rd_en, fr_rd_en);
        if (bg_rd_en && (bg_empty || fr_empty)) chk("pop_while_empty", bg_rd_en, 0);
        if (out_wr_en && out_full) chk("write_while_full", out_wr_en, 0);
        pend_done = 1'b0;
        popped = bg_rd_en && fr_rd_en && bgq.size() != 0 && frq.size() != 0;
        if (popped) begin
            if (in_cnt == 0) fthr = threshold;
            exq.push_back(model(bgq[0], frq[0], fthr, cyc));
            in_cnt = (in_cnt + 1) % N;
            npop++;
        end
        if (out_wr_en) begin
            if (exq.size() == 0) chk("unexpected_write", out_wr_en, 0);
            else begin
                e = exq.pop_front();
                chk("out_din", out_din, e.pix);
                if (chk_lat) chk("latency", cyc - e.cyc, 3);
                if (first_lat < 0) first_lat = cyc - e.cyc;
                if (wcnt == 0) first_out = out_din;
                last_out = out_din;
                nwr++;
                wcnt++;
                macc += int'(e.mot);
                if (wcnt == N) begin
                    wcnt = 0;
                    pend_done = 1'b1;
                    done_cnt++;
`ifdef MOTION_DETECT_COUNT_EN
                    mc_exp = 4'(macc);
`endif
                    macc = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (popped) begin
            void'(bgq.pop_front());
            void'(frq.pop_front());
        end
        bg_empty = bgq.size() == 0;
        fr_empty = frq.size() == 0;
        bg_dout = bg_empty ? 24'h0 : bgq[0];
        fr_dout = fr_empty ? 24'h0 : frq[0];
    end

    task automatic push(input logic [23:0] b, input logic [23:0] f);
        bgq.push_back(b);
        frq.push_back(f);
    endtask

    task automatic drain();
        int k = 0;
        while ((bgq.size() != 0 || exq.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", k < 200, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", bg_rd_en, 0);
        chk("reset_out_din", out_din, 0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rd_en", bg_rd_en, 0);
        chk("idle_wr_en", out_wr_en, 0);
        chk("idle_out_din", out_din, 0);
        chk("idle_frame_done", frame_done, 0);
        chk("idle_motion_count", motion_count, 0);

        // Frame 1 at threshold 0x20; threshold raised right after its first pop
        @(posedge clk);
        #2 threshold = 8'h20;
        chk_lat = 1'b1;
        push(24'h101010, 24'h404040);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bg_rd_en && k < 20);
        chk("first_pop_seen", bg_rd_en, 1);
        @(posedge clk);
        #2 threshold = 8'h30;
        push(24'h101010, 24'h404040);
        push(24'h000000, 24'h303030);
        push(24'h102030, 24'h112131);
        push(24'h808080, 24'h909090);
        push(24'hFF0000, 24'h00FF00);
        push(24'h202020, 24'h000000);
        push(24'h123456, 24'h123456);
        drain();
        chk("frame1_first_out", first_out, 24'hFF0000);
        chk("frame1_first_latency", first_lat, 3);
        chk("frame1_last_out", last_out, 24'h123456);
        chk("frame1_done_count", done_cnt, 1);
`ifdef MOTION_DETECT_COUNT_EN
        chk("frame1_motion_count", motion_count, 3);
`else
        chk("frame1_motion_count", motion_count, 0);
`endif

        // Frame 2 at threshold 0x30: equal-to-threshold difference is not motion
        chk_lat = 1'b0;
        @(posedge clk);
        #2 push(24'h101010, 24'h404040);
        drain();
        chk("frame2_first_out", last_out, 24'h404040);
        @(posedge clk);
        #2;
        push(24'h000000, 24'h404040);
        push(24'h050505, 24'h0A0A0A);
        push(24'hAABBCC, 24'hAABBCC);
        push(24'h010203, 24'h030201);
        push(24'h7F7F7F, 24'h606060);
        push(24'hFFFFFF, 24'hD0D0D0);
        push(24'h000000, 24'h2F2F2F);
        repeat (3) @(posedge clk);
        #2 out_full = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_no_pop", bg_rd_en, 0);
        chk("stall_no_write", out_wr_en, 0);
        @(posedge clk);
        @(posedge clk);
        #2 out_full = 1'b0;
        drain();
        chk("in_out_balance", npop, nwr);
        chk("pixel_total", nwr, 16);
        chk("frame2_done_count", done_cnt, 2);
        chk("frame2_last_out", last_out, 24'h2F2F2F);
`ifdef MOTION_DETECT_COUNT_EN
        chk("frame2_motion_count", motion_count, 1);
`else
        chk("frame2_motion_count", motion_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/motion_detect_stream.md
# motion_detect_stream

Single-module, parametrised successor to the FIFO-composed motion-detect top. It pairs background and frame pixels from two show-ahead FIFOs and grayscales both. It thresholds their absolute difference against a per-frame runtime threshold and writes either the frame pixel or a highlight colour to an output FIFO. It also tracks raster position and reports frame completion and a per-frame motion-pixel count.

## Interface
Parameters:
- WIDTH, 720, pixels per line
- HEIGHT, 540, lines per frame
- PIX_W, 8, bits per colour channel; pixel word is 3*PIX_W, R in MSBs
- HIGHLIGHT_RGB, {PIX_W{1}},{2*PIX_W{0}} (pure red), colour written for motion pixels

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high
- bg_dout  in  3*PIX_W  background pixel, valid while bg_empty low (show-ahead)
- bg_empty  in  1  background FIFO empty
- bg_rd_en  out  1  background pop
- fr_dout  in  3*PIX_W  frame pixel, show-ahead
- fr_empty  in  1  frame FIFO empty
- fr_rd_en  out  1  frame pop
- threshold  in  PIX_W  motion threshold, sampled per frame
- out_din  out  3*PIX_W  output pixel
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output push
- frame_done  out  1  one-cycle pulse after last pixel of a frame is written
- motion_count  out  clog2(WIDTH*HEIGHT+1)  motion pixels in last completed frame

## Operation
- Pipeline: S1, S2, S3 registers, each with a valid bit. The whole pipeline moves on a single `advance = ~s3_valid | ~out_full`.
- Read: `bg_rd_en = fr_rd_en = ~bg_empty & ~fr_empty & advance`. The two pops are always simultaneous, and there is never a pop while either FIFO is empty.
- S1: registers `sum = R+G+B` (PIX_W+2 bits) for bg and fr, the raw frame pixel, and the pixel's threshold.
- S2: computes `gray = sum/3` (floor) for each side and registers `diff = |gray_fr - gray_bg|` (PIX_W bits), along with the frame pixel and threshold.
- S3: `motion = diff > thr` (strict). S3 registers `motion ? HIGHLIGHT_RGB : frame pixel` and the motion flag.
- Output: `out_wr_en = s3_valid & ~out_full`; `out_din` = S3 data. When out_full is high, S3 holds and the pipeline freezes.
- Input counter: in_idx counts from 0 to WIDTH*HEIGHT-1 on each pop and wraps to 0. On the pop with in_idx==0, the threshold port is captured into thr_q. Each pixel carries the thr_q value in force at its pop, so every pixel of a frame uses the same threshold even when frames overlap in the pipeline.
- Output counters: x counts 0..WIDTH-1 and y counts 0..HEIGHT-1, both advancing on out_wr_en. x wraps to 0 with y++ at WIDTH-1. At (WIDTH-1, HEIGHT-1), both wrap to 0.
- Accumulator: acc increments on each out_wr_en carrying a motion pixel. On the last pixel write, motion_count ← acc + motion and acc ← 0.
- frame_done is registered high for exactly one cycle following the last-pixel write.

## Timing
- Reset values: all valid bits 0, rd_en/wr_en 0, out_din 0, frame_done 0, motion_count 0, counters 0, acc 0, thr_q 0.
- Reset asserted mid-frame discards in-flight pixels and restarts counters at pixel 0. FIFOs are reset externally.
- Latency: a pop in cycle N gives out_wr_en in N+3 when out_full is low throughout.
- Throughput: 1 pixel/cycle sustained.
- Back-pressure: each cycle of out_full with s3_valid adds one cycle of latency. No pixel is lost or duplicated.
- Simultaneous pop and write in the same cycle is normal operation.
- frame_done and the motion_count update appear in cycle W+1, where W is the last-pixel write cycle.

## Configuration
- MOTION_DETECT_COUNT_EN defined: acc and motion_count logic as above.
- MOTION_DETECT_COUNT_EN undefined: acc is removed and motion_count is tied to 0. frame_done, the raster counters and the threshold logic are unchanged.

## Test plan
- Reset then idle, both FIFOs empty: no rd_en/wr_en, all outputs 0.
- PIX_W=8, bg=0x101010, fr=0x404040, threshold=0x20: diff 0x30 > 0x20, so out_din=0xFF0000 exactly 3 cycles after the pop.
- Same pixels with threshold=0x30: no motion (strict compare), so out_din=0x404040.
- WIDTH=4, HEIGHT=2, 8 pixels with 3 motion pixels: frame_done pulses once after the 8th write and motion_count=3 (0 without the macro). The next frame restarts at x=y=0.
- Hold out_full high 5 cycles mid-stream: pops stop once S3 holds, the output order is preserved, and the input count equals the output count.
- Change threshold on the cycle after a frame's first pop: the whole frame uses the old threshold and the next frame uses the new one.
